// File: rtl/matmul_calc_pkg.sv
// Shared types and defaults for the systolic matmul_calc sequencer.
// Holds the default array size, the MAC depth, the derived widths and the controller state type.
package matmul_calc_pkg;

    localparam int DEF_MAX_DIM = 4;
    localparam int DEF_MAC_LAT = 2;
    localparam int IDX_W       = $clog2(DEF_MAX_DIM);
    localparam int DIM_W       = $clog2(DEF_MAX_DIM + 1);

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } ctrl_state_e;

    // A dimension is usable when it is 1..max_dim.
    function automatic logic dim_ok(input int dim, input int max_dim);
        return (dim >= 1) && (dim <= max_dim);
    endfunction

endpackage

// File: rtl/matmul_skew_gen.sv
// Diagonal-skew lane generator: lane l presents operand k = t - l while 0 <= t - l < k_len.
// Lanes at or beyond the active count stay idle, and idle lanes drive index 0.
module matmul_skew_gen
    import matmul_calc_pkg::*;
#(
    parameter int LANES      = DEF_MAX_DIM,
    parameter int TIME_W     = DIM_W + 2,
    parameter int CNT_W      = DIM_W,
    parameter int LANE_IDX_W = IDX_W
) (
    input  logic                        en,
    input  logic [TIME_W-1:0]           t,
    input  logic [CNT_W-1:0]            active,
    input  logic [CNT_W-1:0]            k_len,
    output logic [LANES-1:0]            valid,
    output logic [LANES*LANE_IDX_W-1:0] idx
);

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        localparam logic [TIME_W-1:0] LANE = TIME_W'(l);

        logic [TIME_W-1:0] rel;
        logic              lane_on;

        // rel is only meaningful once t >= LANE, so that term guards the wrapped case.
        assign rel     = t - LANE;
        assign lane_on = en && (LANE < TIME_W'(active)) && (t >= LANE)
                         && (rel < TIME_W'(k_len));

        assign valid[l]                              = lane_on;
        assign idx[l*LANE_IDX_W +: LANE_IDX_W]       = lane_on ? rel[LANE_IDX_W-1:0] : '0;
    end

endmodule

// File: rtl/matmul_calc_ctrl.sv
// Sequencer for the systolic matmul datapath: clear, skewed A/B feed, MAC drain, done pulse.
// Outputs are flops loaded from the next state and next t, so they line up with the state register.
module matmul_calc_ctrl
    import matmul_calc_pkg::*;
#(
    parameter int MAX_DIM = DEF_MAX_DIM,
    parameter int MAC_LAT = DEF_MAC_LAT,
    localparam int D_W    = $clog2(MAX_DIM + 1),
    localparam int I_W    = $clog2(MAX_DIM)
) (
    input  logic                   clk,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [D_W-1:0]         n_i,
    input  logic [D_W-1:0]         k_i,
    input  logic [D_W-1:0]         m_i,
    output logic                   busy_o,
    output logic                   pe_clear_o,
    output logic [MAX_DIM-1:0]     a_valid_o,
    output logic [MAX_DIM*I_W-1:0] a_k_o,
    output logic [MAX_DIM-1:0]     b_valid_o,
    output logic [MAX_DIM*I_W-1:0] b_k_o,
    output logic                   done_o,
    output logic                   err_o
);

    localparam int T_W = D_W + 2;
    localparam int L_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    ctrl_state_e            state_q, state_d;
    logic [T_W-1:0]         t_q, t_d, t_last;
    logic [L_W-1:0]         drain_q, drain_d;
    logic [D_W-1:0]         n_q, k_q, m_q, n_d, k_d, m_d;
    logic                   err_d, start_ok, feed_d;
    logic [MAX_DIM-1:0]     a_valid_d, b_valid_d;
    logic [MAX_DIM*I_W-1:0] a_k_d, b_k_d;

    assign start_ok = dim_ok(int'(n_i), MAX_DIM) && dim_ok(int'(k_i), MAX_DIM)
                      && dim_ok(int'(m_i), MAX_DIM);
    assign t_last   = T_W'(n_q) + T_W'(k_q) + T_W'(m_q) - T_W'(3);

    always_comb begin
        // NOTE: every combinational output gets a default first; a missed branch would infer a latch.
        state_d = state_q;
        t_d     = t_q;
        drain_d = drain_q;
        n_d     = n_q;
        k_d     = k_q;
        m_d     = m_q;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (start_ok) begin
                        n_d     = n_i;
                        k_d     = k_i;
                        m_d     = m_i;
                        state_d = CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                t_d     = '0;
                state_d = FEED;
            end
            FEED: begin
                if (t_q == t_last) begin
                    drain_d = L_W'(MAC_LAT - 1);
                    state_d = DRAIN;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == '0) state_d = DONE;
                else               drain_d = drain_q - 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort overrides every transition, but an idle controller has nothing to abandon.
        if (abort_i && (state_q != IDLE)) state_d = IDLE;
    end

    assign feed_d = (state_d == FEED);

    matmul_skew_gen #(
        .LANES      (MAX_DIM),
        .TIME_W     (T_W),
        .CNT_W      (D_W),
        .LANE_IDX_W (I_W)
    ) u_row_skew (
        .en     (feed_d),
        .t      (t_d),
        .active (n_q),
        .k_len  (k_q),
        .valid  (a_valid_d),
        .idx    (a_k_d)
    );

    matmul_skew_gen #(
        .LANES      (MAX_DIM),
        .TIME_W     (T_W),
        .CNT_W      (D_W),
        .LANE_IDX_W (I_W)
    ) u_col_skew (
        .en     (feed_d),
        .t      (t_d),
        .active (m_q),
        .k_len  (k_q),
        .valid  (b_valid_d),
        .idx    (b_k_d)
    );

    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            t_q        <= '0;
            drain_q    <= '0;
            n_q        <= '0;
            k_q        <= '0;
            m_q        <= '0;
            busy_o     <= 1'b0;
            pe_clear_o <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            a_valid_o  <= '0;
            a_k_o      <= '0;
            b_valid_o  <= '0;
            b_k_o      <= '0;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            drain_q    <= drain_d;
            n_q        <= n_d;
            k_q        <= k_d;
            m_q        <= m_d;
            busy_o     <= (state_d != IDLE);
            pe_clear_o <= (state_d == CLEAR);
            done_o     <= (state_d == DONE);
            err_o      <= err_d;
            a_valid_o  <= a_valid_d;
            a_k_o      <= a_k_d;
            b_valid_o  <= b_valid_d;
            b_k_o      <= b_k_d;
        end
    end

endmodule
